// File: rtl/packet_assembler.sv
// packet_assembler: builds egress AXI-Stream packets made of HDR_BEATS header
// beats followed by a commanded number of payload beats popped in lockstep
// from the SIMD lane FIFOs. m_tlast is generated here.
// Optional feature: define ASM_PKT_CNT_EN to enable the completed-packet
// counter on pkt_count; otherwise pkt_count is tied to zero.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// HEADER  | forwarding header beats from hdr_tdata
// PAYLOAD | draining lane FIFO heads, one all-lane pop per beat
module packet_assembler #(
  parameter int SIMD_DEGREE = 4,
  parameter int LANE_W      = 32,
  parameter int HDR_BEATS   = 40,
  parameter int LEN_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [LEN_W-1:0]              cmd_len,
  input  logic [SIMD_DEGREE*LANE_W-1:0] hdr_tdata,
  input  logic                          hdr_tvalid,
  output logic                          hdr_tready,
  input  logic [SIMD_DEGREE*LANE_W-1:0] lane_dout,
  input  logic [SIMD_DEGREE-1:0]        lane_empty,
  output logic [SIMD_DEGREE-1:0]        lane_rd_en,
  output logic [SIMD_DEGREE*LANE_W-1:0] m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic [1:0]                    state,
  output logic [31:0]                   pkt_count
);

  localparam int HCW = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_HEADER  = 2'b01,
    S_PAYLOAD = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [HCW-1:0]   hdr_cnt_q, hdr_cnt_d;
  logic [LEN_W-1:0] pay_cnt_q, pay_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic hdr_last;
  logic pay_last;
  logic lanes_full;
  logic beat;

  assign hdr_last   = (hdr_cnt_q == HCW'(HDR_BEATS - 1));
  assign pay_last   = (pay_cnt_q == (len_q - LEN_W'(1)));
  assign lanes_full = ~|lane_empty;
  assign beat       = m_tvalid & m_tready;
  assign state      = state_q;

  // State and counter registers; reset aborts any packet in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      hdr_cnt_q <= '0;
      pay_cnt_q <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      len_q     <= len_d;
    end
  end

  // Next-state and counter update; counters only move on accepted beats.
  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    pay_cnt_d = pay_cnt_q;
    len_d     = len_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          len_d     = cmd_len;
          hdr_cnt_d = '0;
          pay_cnt_d = '0;
          state_d   = S_HEADER;
        end
      end
      S_HEADER: begin
        if (beat) begin
          hdr_cnt_d = hdr_cnt_q + HCW'(1);
          if (hdr_last) state_d = (len_q == '0) ? S_IDLE : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (beat) begin
          pay_cnt_d = pay_cnt_q + LEN_W'(1);
          if (pay_last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stream outputs; m_tvalid is never a function of m_tready.
  always_comb begin
    cmd_ready  = 1'b0;
    hdr_tready = 1'b0;
    m_tvalid   = 1'b0;
    m_tlast    = 1'b0;
    m_tdata    = '0;
    lane_rd_en = '0;
    case (state_q)
      S_IDLE: cmd_ready = 1'b1;
      S_HEADER: begin
        m_tdata    = hdr_tdata;
        m_tvalid   = hdr_tvalid;
        hdr_tready = m_tready;
        m_tlast    = hdr_last && (len_q == '0);
      end
      S_PAYLOAD: begin
        m_tdata    = lane_dout;
        m_tvalid   = lanes_full;
        m_tlast    = pay_last;
        lane_rd_en = {SIMD_DEGREE{lanes_full & m_tready}};
      end
      default: ;
    endcase
  end

`ifdef ASM_PKT_CNT_EN
  logic [31:0] pkt_cnt_q;

  // Count packets whose final beat was accepted; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pkt_cnt_q <= '0;
    else if (beat && m_tlast) pkt_cnt_q <= pkt_cnt_q + 32'd1;
  end

  assign pkt_count = pkt_cnt_q;
`else
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_packet_assembler.sv
// Directed bench for packet_assembler with a lane-FIFO / header-source model
// and a beat scoreboard filled when each command is issued.
module tb_packet_assembler;
  localparam int S     = 2;
  localparam int LW    = 16;
  localparam int HB    = 40;
  localparam int LEN_W = 16;
  localparam int DW    = S * LW;
`ifdef ASM_PKT_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic [DW-1:0]    hdr_tdata;
  logic             hdr_tvalid;
  logic             hdr_tready;
  logic [DW-1:0]    lane_dout;
  logic [S-1:0]     lane_empty;
  logic [S-1:0]     lane_rd_en;
  logic [DW-1:0]    m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;
  logic [1:0]       state;
  logic [31:0]      pkt_count;

  always #5 clk = ~clk;

  packet_assembler #(
    .SIMD_DEGREE(S), .LANE_W(LW), .HDR_BEATS(HB), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .hdr_tdata(hdr_tdata), .hdr_tvalid(hdr_tvalid), .hdr_tready(hdr_tready),
    .lane_dout(lane_dout), .lane_empty(lane_empty), .lane_rd_en(lane_rd_en),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .state(state), .pkt_count(pkt_count)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          pay;
  } beat_t;

  beat_t        sb[$];
  logic [LW-1:0] lane_fifo [S][$];
  int           errors = 0;
  int           checks = 0;
  int unsigned  hdr_seq = 0;
  int unsigned  exp_hdr_seq = 0;
  bit           pop_pending = 0;
  bit           hdr_adv = 0;
  int           beat_total = 0;
  int           pop_total = 0;
  int           last_total = 0;
  bit           prev_stall = 0;
  logic [DW-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] word(input int base, input int k, input int l);
    return LW'(base + k * 16 + l);
  endfunction

  function automatic void refresh();
    for (int i = 0; i < S; i++) begin
      lane_empty[i] = (lane_fifo[i].size() == 0);
      lane_dout[i*LW +: LW] = lane_empty[i] ? '0 : lane_fifo[i][0];
    end
    hdr_tdata = DW'(32'h5A00_0000 + hdr_seq);
  endfunction

  // FIFO heads and header source advance on the edge after a handshake.
  always @(posedge clk) begin
    if (pop_pending) begin
      for (int i = 0; i < S; i++)
        if (lane_fifo[i].size() > 0) void'(lane_fifo[i].pop_front());
      pop_pending = 0;
    end
    if (hdr_adv) begin
      hdr_seq++;
      hdr_adv = 0;
    end
    refresh();
  end

  // Output monitor: scoreboard compare on every accepted beat.
  always @(negedge clk) begin
    if (rst) begin
      beat_t e;
      if (prev_stall) begin
        check("stall_valid", DW'(m_tvalid), DW'(1));
        check("stall_data", m_tdata, prev_data);
      end
      if (hdr_tvalid && hdr_tready) hdr_adv = 1;
      if (m_tvalid && m_tready) begin
        beat_total++;
        check("sb_nonempty", DW'(sb.size() > 0), DW'(1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("beat_data", m_tdata, e.data);
          check("beat_last", DW'(m_tlast), DW'(e.last));
          check("beat_rd_en", DW'(lane_rd_en), e.pay ? DW'({S{1'b1}}) : DW'(0));
        end
        if (m_tlast) last_total++;
        if (&lane_rd_en) begin
          pop_total++;
          pop_pending = 1;
        end
      end else begin
        check("rd_en_no_beat", DW'(lane_rd_en), DW'(0));
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end
  end

  task automatic expect_pkt(input int len, input int base);
    beat_t b;
    for (int i = 0; i < HB; i++) begin
      b.data = DW'(32'h5A00_0000 + exp_hdr_seq);
      exp_hdr_seq++;
      b.last = (len == 0) && (i == HB - 1);
      b.pay  = 1'b0;
      sb.push_back(b);
    end
    for (int k = 0; k < len; k++) begin
      for (int l = 0; l < S; l++) b.data[l*LW +: LW] = word(base, k, l);
      b.last = (k == len - 1);
      b.pay  = 1'b1;
      sb.push_back(b);
    end
  endtask

  task automatic fill_lanes(input int len, input int base, input int first_lane, input int last_lane);
    for (int l = first_lane; l <= last_lane; l++)
      for (int k = 0; k < len; k++) lane_fifo[l].push_back(word(base, k, l));
    refresh();
  endtask

  task automatic send_cmd(input int len);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("cmd_to_header", DW'(state), DW'(2'b01));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(state == 2'b00 && sb.size() == 0) && n < budget);
    check(tag, DW'(state == 2'b00 && sb.size() == 0), DW'(1));
  endtask

  initial begin
    int b0, p0, l0, n, idle_cyc, cyc;
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_len = '0;
    hdr_tvalid = 1'b1;
    m_tready = 1'b1;
    refresh();
    #2;
    check("rst_state", DW'(state), DW'(0));
    check("rst_tvalid", DW'(m_tvalid), DW'(0));
    check("rst_tlast", DW'(m_tlast), DW'(0));
    check("rst_rd_en", DW'(lane_rd_en), DW'(0));
    check("rst_hdr_tready", DW'(hdr_tready), DW'(0));
    check("rst_cmd_ready", DW'(cmd_ready), DW'(1));
    check("rst_pkt_count", DW'(pkt_count), DW'(0));
    #10 rst = 1'b1;

    // Header-only packet
    b0 = beat_total; p0 = pop_total; l0 = last_total;
    expect_pkt(0, 0);
    send_cmd(0);
    wait_idle("hdr_only_done", 200);
    check("hdr_only_beats", DW'(beat_total - b0), DW'(HB));
    check("hdr_only_pops", DW'(pop_total - p0), DW'(0));
    check("hdr_only_lasts", DW'(last_total - l0), DW'(1));

    // Normal packet, lanes pre-filled
    b0 = beat_total; p0 = pop_total;
    fill_lanes(3, 'h100, 0, S - 1);
    expect_pkt(3, 'h100);
    send_cmd(3);
    wait_idle("normal_done", 200);
    check("normal_beats", DW'(beat_total - b0), DW'(HB + 3));
    check("normal_pops", DW'(pop_total - p0), DW'(3));

    // Partial lanes: lane 0 starts empty
    b0 = beat_total; p0 = pop_total;
    fill_lanes(2, 'h200, 1, S - 1);
    expect_pkt(2, 'h200);
    send_cmd(2);
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (state != 2'b10 && n < 200);
    check("partial_reach_payload", DW'(state), DW'(2'b10));
    for (int c = 0; c < 5; c++) begin
      check("partial_tvalid_low", DW'(m_tvalid), DW'(0));
      check("partial_no_pop", DW'(pop_total - p0), DW'(0));
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    fill_lanes(2, 'h200, 0, 0);
    wait_idle("partial_done", 100);
    check("partial_beats", DW'(beat_total - b0), DW'(HB + 2));
    check("partial_pops", DW'(pop_total - p0), DW'(2));

    // Back-pressure: m_tready toggled every cycle
    b0 = beat_total; p0 = pop_total;
    fill_lanes(4, 'h300, 0, S - 1);
    expect_pkt(4, 'h300);
    send_cmd(4);
    n = 0;
    while (state != 2'b00 && n < 400) begin
      @(posedge clk); #1;
      m_tready = ~m_tready;
      n++;
    end
    m_tready = 1'b1;
    wait_idle("bp_done", 20);
    check("bp_beats", DW'(beat_total - b0), DW'(HB + 4));
    check("bp_pops", DW'(pop_total - p0), DW'(4));
    check("pkt_count_4", DW'(pkt_count), CNT_ON ? DW'(4) : DW'(0));

    // Async reset mid-payload after beat 42
    b0 = beat_total; p0 = pop_total; l0 = last_total;
    fill_lanes(5, 'h400, 0, S - 1);
    expect_pkt(5, 'h400);
    send_cmd(5);
    n = 0;
    while ((beat_total - b0) < HB + 2 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("rst_mid_reached", DW'(beat_total - b0), DW'(HB + 2));
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("async_rst_state", DW'(state), DW'(0));
    check("async_rst_tvalid", DW'(m_tvalid), DW'(0));
    check("async_rst_pkt_count", DW'(pkt_count), DW'(0));
    check("async_rst_pops", DW'(pop_total - p0), DW'(2));
    check("async_rst_no_last", DW'(last_total - l0), DW'(0));
    sb.delete();
    for (int l = 0; l < S; l++) lane_fifo[l].delete();
    refresh();
    #1 rst = 1'b1;

    b0 = beat_total;
    fill_lanes(5, 'h500, 0, S - 1);
    expect_pkt(5, 'h500);
    send_cmd(5);
    wait_idle("post_rst_done", 200);
    check("post_rst_beats", DW'(beat_total - b0), DW'(HB + 5));
    check("pkt_count_1", DW'(pkt_count), CNT_ON ? DW'(1) : DW'(0));

    // Three back-to-back header-only packets
    l0 = last_total;
    expect_pkt(0, 0);
    expect_pkt(0, 0);
    expect_pkt(0, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_len = '0;
    idle_cyc = 0;
    cyc = 0;
    do begin
      @(negedge clk); #1;
      cyc++;
      if (state == 2'b00) idle_cyc++;
    end while ((last_total - l0) < 3 && cyc < 400);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("b2b_cycles", DW'(cyc), DW'(3 * (HB + 1)));
    check("b2b_idle_cycles", DW'(idle_cyc), DW'(3));
    wait_idle("b2b_done", 20);
    check("pkt_count_b2b", DW'(pkt_count), CNT_ON ? DW'(4) : DW'(0));
    check("sb_drained", DW'(sb.size()), DW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
